// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: monitor state type, 640x480@60 default timing and frame-total helpers
package vga_timing_pkg;
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} mon_state_t;
  localparam int CNT_W = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_PULSE = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_PULSE = 2;
  localparam int DEF_V_BP = 33;
  function automatic int h_total(input int active, input int fp, input int pulse, input int bp);
    return pulse + bp + active + fp;
  endfunction
  function automatic int v_total(input int active, input int fp, input int pulse, input int bp);
    return pulse + bp + active + fp;
  endfunction
endpackage

// File: rtl/vga_axis_tracker.sv
// vga_axis_tracker: sync edge detect, saturating position counter and pulse-width/period checks for one axis
module vga_axis_tracker
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = 800,
  parameter int PULSE = 96,
  parameter bit POL = 1'b0,
  parameter bit OVR_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             sync,
  output logic             hit,
  output logic             err,
  output logic [CNT_W-1:0] pos,
  output logic [CNT_W-1:0] nxt
);
  logic sync_d, run, ovr, fall, last;
  always_comb begin
    hit = (sync == POL) && (sync_d != POL);
    fall = (sync != POL) && (sync_d == POL);
    last = pos == CNT_W'(TOTAL - 1);
    nxt = hit ? '0 : (step && !last) ? pos + CNT_W'(1) : pos;
    err = run && ((hit && !last) || (fall && pos != CNT_W'(PULSE - 1)) || (OVR_ERR && step && last && !hit && !ovr));
  end
  always_ff @(posedge clk)
    if (rst) begin
      sync_d <= POL;
      run <= 1'b0;
      ovr <= 1'b0;
      pos <= '0;
    end else begin
      sync_d <= sync;
      run <= run | hit;
      ovr <= !hit && (ovr || (step && last));
      pos <= nxt;
    end
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: VGA sync/DE receiver with coordinate recovery, lock FSM and error pulses; VGA_MON_STATS_EN adds error/frame counters
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_PULSE = DEF_H_PULSE,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_PULSE = DEF_V_PULSE,
  parameter int V_BP = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clock,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        display_enable,
  output logic [9:0]  rec_column,
  output logic [9:0]  rec_row,
  output logic        pixel_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        h_error,
  output logic        v_error,
  output logic        de_error,
  output logic [7:0]  error_count,
  output logic [15:0] frame_count
);
  localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_PULSE, H_BP);
  localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_PULSE, V_BP);
  localparam int H_OFF = H_PULSE + H_BP;
  localparam int V_OFF = V_PULSE + V_BP;
  logic hs_r, vs_r, de_r, h_hit, v_hit, h_err, v_err, de_err, dirty, dirty_nxt;
  logic [CNT_W-1:0] hc, vc, hc_nxt, vc_nxt;
  logic [7:0] cnt, cnt_nxt;
  mon_state_t state, state_nxt;
  function automatic logic in_act(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
    return h >= CNT_W'(H_OFF) && h < CNT_W'(H_OFF + H_ACTIVE) && v >= CNT_W'(V_OFF) && v < CNT_W'(V_OFF + V_ACTIVE);
  endfunction
  vga_axis_tracker #(.TOTAL(H_TOT), .PULSE(H_PULSE), .POL(SYNC_POL), .OVR_ERR(1'b1)) u_h (
    .clk(vga_clock), .rst(reset), .step(1'b1), .sync(hs_r),
    .hit(h_hit), .err(h_err), .pos(hc), .nxt(hc_nxt)
  );
  vga_axis_tracker #(.TOTAL(V_TOT), .PULSE(V_PULSE), .POL(SYNC_POL), .OVR_ERR(1'b0)) u_v (
    .clk(vga_clock), .rst(reset), .step(h_hit), .sync(vs_r),
    .hit(v_hit), .err(v_err), .pos(vc), .nxt(vc_nxt)
  );
  always_comb begin
    locked = state == LOCKED;
    de_err = locked && (de_r != in_act(hc_nxt, vc_nxt));
    pixel_valid = locked && in_act(hc, vc);
    rec_column = pixel_valid ? hc - CNT_W'(H_OFF) : '0;
    rec_row = pixel_valid ? vc - CNT_W'(V_OFF) : '0;
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = (h_err || v_err) ? '0 : cnt;
    dirty_nxt = dirty | h_err | v_err;
    unique case (state)
      SEARCH: if (v_hit) begin
        state_nxt = ALIGN;
        cnt_nxt = '0;
        dirty_nxt = 1'b0;
      end
      ALIGN: if (v_hit) begin
        cnt_nxt = (dirty || h_err || v_err) ? '0 : cnt + 8'd1;
        dirty_nxt = 1'b0;
        state_nxt = (cnt_nxt == 8'(LOCK_FRAMES)) ? LOCKED : ALIGN;
      end
      LOCKED: state_nxt = (h_err || v_err) ? SEARCH : LOCKED;
      default: state_nxt = SEARCH;
    endcase
  end
  always_ff @(posedge vga_clock)
    if (reset) begin
      hs_r <= SYNC_POL;
      vs_r <= SYNC_POL;
      de_r <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      h_error <= 1'b0;
      v_error <= 1'b0;
      de_error <= 1'b0;
      state <= SEARCH;
      cnt <= '0;
      dirty <= 1'b0;
    end else begin
      hs_r <= hsync;
      vs_r <= vsync;
      de_r <= display_enable;
      line_start <= h_hit;
      frame_start <= v_hit;
      h_error <= h_err;
      v_error <= v_err;
      de_error <= de_err;
      state <= state_nxt;
      cnt <= cnt_nxt;
      dirty <= dirty_nxt;
    end
`ifdef VGA_MON_STATS_EN
  logic [8:0] err_sum;
  always_comb err_sum = {1'b0, error_count} + 9'(h_err) + 9'(v_err) + 9'(de_err);
  always_ff @(posedge vga_clock)
    if (reset) begin
      error_count <= '0;
      frame_count <= '0;
    end else begin
      error_count <= err_sum[8] ? 8'hff : err_sum[7:0];
      frame_count <= frame_count + 16'(v_hit);
    end
`else
  assign error_count = '0;
  assign frame_count = '0;
`endif
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed checks of lock, coordinates, error pulses and reset on a scaled-down raster
module tb_vga_timing_monitor;
  localparam int HA = 8, HF = 2, HP = 3, HB = 3;
  localparam int VA = 6, VF = 2, VP = 2, VB = 2;
  localparam int HT = HA + HF + HP + HB;
  localparam int VT = VA + VF + VP + VB;
  localparam int FT = HT * VT;
`ifdef VGA_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic vga_clock = 1'b0, reset = 1'b1, hsync = 1'b1, vsync = 1'b1, display_enable = 1'b0;
  logic [9:0] rec_column, rec_row;
  logic pixel_valid, line_start, frame_start, locked, h_error, v_error, de_error;
  logic [7:0] error_count;
  logic [15:0] frame_count;
  int passed = 0, total = 0;
  int gh = 0, gv = 0, line_len = HT, vp_len = VP;
  bit stretch = 0, de_kill = 0, locked_q = 0;
  int ph1_h = 0, ph1_v = 0, ph2_h = 0, ph2_v = 0;
  int cyc = 0, fs_cyc = 0, fs_gap = 0;
  int n_herr, n_verr, n_deerr, n_fs, n_ls, n_pv, n_drop, lock_fs, first_px, last_px;
  int n_bad = 0, herr_locked = -1, verr_locked = -1, verr_at = -1, de_locked = -1, de_at = -1;
  always #5 vga_clock = ~vga_clock;
  vga_timing_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_PULSE(VP), .V_BP(VB),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .vga_clock(vga_clock), .reset(reset), .hsync(hsync), .vsync(vsync), .display_enable(display_enable),
    .rec_column(rec_column), .rec_row(rec_row), .pixel_valid(pixel_valid), .line_start(line_start),
    .frame_start(frame_start), .locked(locked), .h_error(h_error), .v_error(v_error), .de_error(de_error),
    .error_count(error_count), .frame_count(frame_count)
  );
  function automatic bit reg_act(input int h, input int v);
    return h >= HP + HB && h < HP + HB + HA && v >= VP + VB && v < VP + VB + VA;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
  endtask
  task automatic clear();
    n_herr = 0; n_verr = 0; n_deerr = 0; n_fs = 0; n_ls = 0; n_pv = 0; n_drop = 0;
    lock_fs = -1; first_px = -1; last_px = -1;
  endtask
  task automatic tick();
    @(negedge vga_clock);
    cyc++;
    if (h_error) begin n_herr++; herr_locked = int'(locked); end
    if (v_error) begin n_verr++; verr_locked = int'(locked); verr_at = ph2_v * 100 + ph2_h; end
    if (de_error) begin n_deerr++; de_locked = int'(locked); de_at = ph2_v * 100 + ph2_h; end
    if (frame_start) begin n_fs++; fs_gap = cyc - fs_cyc; fs_cyc = cyc; end
    if (line_start) n_ls++;
    if (locked && !locked_q) lock_fs = n_fs;
    if (!locked && locked_q) n_drop++;
    locked_q = locked;
    if (pixel_valid !== (locked && reg_act(ph2_h, ph2_v))) n_bad++;
    if (pixel_valid) begin
      if (int'(rec_column) != ph2_h - HP - HB || int'(rec_row) != ph2_v - VP - VB) n_bad++;
      if (first_px < 0) first_px = int'(rec_row) * 100 + int'(rec_column);
      last_px = int'(rec_row) * 100 + int'(rec_column);
      n_pv++;
    end else if (rec_column !== 10'd0 || rec_row !== 10'd0) n_bad++;
    ph2_h = ph1_h; ph2_v = ph1_v; ph1_h = gh; ph1_v = gv;
    hsync = !(gh < HP);
    vsync = !(gv < vp_len);
    display_enable = reg_act(gh, gv) && !(de_kill && gh == HP + HB + 1 && gv == VP + VB + 2);
    gh++;
    if (gh >= line_len) begin
      gh = 0;
      gv = (gv + 1) % VT;
      line_len = stretch ? HT + 1 : HT;
      stretch = 0;
    end
  endtask
  initial begin
    clear();
    for (int i = 0; i < 4; i++) tick();
    check("rst_locked", locked, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pulses", {line_start, frame_start, h_error, v_error, de_error}, 0);
    check("rst_coord", {rec_column, rec_row}, 0);
    check("rst_error_count", error_count, 0);
    check("rst_frame_count", frame_count, 0);
    reset = 1'b0;
    clear();
    for (int i = 0; i < 5 * FT && lock_fs < 0; i++) tick();
    check("lock_at_fs", lock_fs, 3);
    check("lock_with_frame_start", frame_start, 1);
    check("lock_clean_errs", n_herr + n_verr + n_deerr, 0);
    clear();
    for (int i = 0; i < FT; i++) tick();
    check("frame_fs_count", n_fs, 1);
    check("frame_period", fs_gap, FT);
    check("frame_line_starts", n_ls, VT);
    check("frame_pixels", n_pv, HA * VA);
    check("first_pixel", first_px, 0);
    check("last_pixel", last_px, (VA - 1) * 100 + HA - 1);
    check("frame_errs", n_herr + n_verr + n_deerr, 0);
    check("frame_still_locked", locked, 1);
    check("frame_count_4", frame_count, STATS ? 4 : 0);
    stretch = 1;
    clear();
    for (int i = 0; i < 5 * FT && lock_fs < 0; i++) tick();
    check("stretch_herr", n_herr, 1);
    check("stretch_unlock_same_cycle", herr_locked, 0);
    check("stretch_drops", n_drop, 1);
    check("stretch_verr", n_verr, 0);
    check("stretch_relock_fs", lock_fs, 3);
    check("stretch_error_count", error_count, STATS ? 1 : 0);
    vp_len = 3;
    clear();
    for (int i = 0; i < 2 * FT && n_verr == 0; i++) tick();
    vp_len = VP;
    check("vpulse_verr", n_verr, 1);
    check("vpulse_at_deassert", verr_at, 3 * 100);
    check("vpulse_unlock", verr_locked, 0);
    check("vpulse_herr", n_herr, 0);
    check("vpulse_error_count", error_count, STATS ? 2 : 0);
    clear();
    for (int i = 0; i < 5 * FT && lock_fs < 0; i++) tick();
    check("vpulse_relock_fs", lock_fs, 3);
    check("vpulse_relock_errs", n_herr + n_verr, 0);
    de_kill = 1;
    clear();
    for (int i = 0; i < FT; i++) tick();
    de_kill = 0;
    check("de_err_count", n_deerr, 1);
    check("de_err_pos", de_at, (VP + VB + 2) * 100 + HP + HB + 1);
    check("de_err_locked", de_locked, 1);
    check("de_no_drop", n_drop, 0);
    check("de_error_count", error_count, STATS ? 3 : 0);
    for (int i = 0; i < FT && !(gv == 6 && gh == 5); i++) tick();
    check("pre_reset_locked", locked, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_locked", locked, 0);
    check("mid_rst_pixel", {pixel_valid, rec_column, rec_row}, 0);
    check("mid_rst_pulses", {line_start, frame_start, h_error, v_error, de_error}, 0);
    check("mid_rst_counts", {error_count, frame_count}, 0);
    reset = 1'b0;
    clear();
    for (int i = 0; i < 5 * FT && lock_fs < 0; i++) tick();
    check("mid_rst_relock_fs", lock_fs, 3);
    check("mid_rst_errs", n_herr + n_verr + n_deerr, 0);
    check("mid_rst_error_count", error_count, 0);
    check("mid_rst_frame_count", frame_count, STATS ? 3 : 0);
    check("coord_mismatches", n_bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
